// File: rtl/udp_fifo_pkg.sv
// Shared helpers for the UDP packet FIFO: depth derivation, pointer distance, flag thresholds.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package udp_fifo_pkg;

    // Number of words held by a FIFO addressed with aw bits
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Distance a-b between two (aw+1)-bit pointers, modulo 2^(aw+1)
    function automatic int unsigned ptr_diff(input int unsigned a, input int unsigned b,
                                             input int unsigned aw);
        return (a - b) & ((32'd1 << (aw + 32'd1)) - 32'd1);
    endfunction

    // Write occupancy at or above which afull is raised
    function automatic int unsigned afull_level(input int unsigned depth, input int unsigned num);
        return depth - num;
    endfunction

    // Read occupancy at or below which aempty is raised
    function automatic int unsigned aempty_level(input int unsigned num);
        return num;
    endfunction

endpackage

// File: rtl/udp_pkt_fifo_ram.sv
// Simple dual-port word store for the packet FIFO, one write port and one read port.
// Latency: o_adat is combinational from i_raddr; o_qdat is one cycle after i_rd_en when REG_OUT=1.
// Backpressure: none, the caller guarantees address validity.
module udp_pkt_fifo_ram
    import udp_fifo_pkg::*;
#(
    parameter int               WIDTH    = 33,
    parameter int               AW       = 7,
    parameter bit               REG_OUT  = 1'b0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdat,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_adat,
    output logic [WIDTH-1:0] o_qdat
);

    localparam int DEPTH = int'(depth_of(AW));

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    // Storage is not reset; the FIFO pointers decide what is meaningful
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    // Registered read port, holds its value between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= INIT_VAL;
        end else if (i_rd_en) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_adat = r_mem[i_raddr];
    assign o_qdat = REG_OUT ? r_q : o_adat;

endmodule

// File: rtl/udp_pkt_fifo.sv
// Packet-aware FIFO: frames become readable only once their eop word commits; aborted/overflowed frames roll back.
// Latency: committed word visible the cycle after the commit edge; registered-read mode adds one cycle from re to dout.
// Backpressure: none upstream; writes while full are dropped with an overflow pulse and poison the frame.
module udp_pkt_fifo
    import udp_fifo_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 7,
    parameter bit                    SHOW_AHEAD_EN = 1'b1,
    parameter int                    AL_FULL_NUM   = 3,
    parameter int                    AL_EMPTY_NUM  = 2,
    parameter int                    PKT_CNT_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DOUT_INITVAL  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    di,
    input  logic                     we,
    input  logic                     wr_eop,
    input  logic                     wr_drop,
    input  logic                     re,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_eop,
    output logic                     valid,
    output logic                     empty_flag,
    output logic                     aempty,
    output logic                     full_flag,
    output logic                     afull,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     wr_success,
    output logic                     frame_dropped,
    output logic [ADDR_WIDTH:0]      wrusedw,
    output logic [ADDR_WIDTH:0]      rdusedw,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);

    localparam int                     PW        = ADDR_WIDTH + 1;
    localparam int                     MW        = DATA_WIDTH + 1;
    localparam int unsigned            DEPTH     = depth_of(ADDR_WIDTH);
    localparam logic [PW-1:0]          LP_DEPTH  = PW'(DEPTH);
    localparam logic [PW-1:0]          LP_AFULL  = PW'(afull_level(DEPTH, AL_FULL_NUM));
    localparam logic [PW-1:0]          LP_AEMPTY = PW'(aempty_level(AL_EMPTY_NUM));
    localparam logic [PKT_CNT_WIDTH-1:0] LP_PKT_MAX = '1;

    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_cptr;
    logic [PW-1:0]            r_rptr;
    logic                     r_err;
    logic                     r_valid;
    logic                     r_overflow;
    logic                     r_underflow;
    logic                     r_wr_success;
    logic                     r_frame_dropped;
    logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;

    logic [PW-1:0] w_wrusedw;
    logic [PW-1:0] w_rdusedw;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_ovf;
    logic          w_eop_bad;
    logic          w_commit;
    logic          w_rollback;
    logic          w_drop_pulse;
    logic          w_rd;
    logic          w_rd_eop;
    logic [MW-1:0] w_ram_adat;
    logic [MW-1:0] w_ram_qdat;

    // Occupancy counts uncommitted words on the write side only
    assign w_wrusedw = PW'(ptr_diff(32'(r_wptr), 32'(r_rptr), ADDR_WIDTH));
    assign w_rdusedw = PW'(ptr_diff(32'(r_cptr), 32'(r_rptr), ADDR_WIDTH));
    assign w_full    = (w_wrusedw == LP_DEPTH);
    assign w_empty   = (w_rdusedw == '0);

    // wr_drop pre-empts any write in the same cycle
    assign w_wr       = we & ~w_full & ~wr_drop;
    assign w_ovf      = we &  w_full & ~wr_drop;
    assign w_eop_bad  = we & wr_eop & ~wr_drop & (r_err | w_full);
    assign w_commit   = w_wr & wr_eop & ~r_err;
    assign w_rollback = wr_drop | w_eop_bad;
    // A drop of an empty frame is silent; a poisoned eop always reports
    assign w_drop_pulse = w_eop_bad | (wr_drop & (r_wptr != r_cptr));

    assign w_rd     = re & ~w_empty;
    assign w_rd_eop = w_rd & w_ram_adat[DATA_WIDTH];

    udp_pkt_fifo_ram #(
        .WIDTH    (MW),
        .AW       (ADDR_WIDTH),
        .REG_OUT  (!SHOW_AHEAD_EN),
        .INIT_VAL ({1'b0, DOUT_INITVAL})
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_wr),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdat  ({wr_eop, di}),
        .i_rd_en (w_rd),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_adat  (w_ram_adat),
        .o_qdat  (w_ram_qdat)
    );

    // Write/commit/read pointers and the frame-poison flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_cptr <= '0;
            r_rptr <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_rollback) begin
                r_wptr <= r_cptr;
            end else if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_commit) begin
                r_cptr <= r_wptr + PW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PW'(1);
            end
            // Any rollback starts a clean frame, even a silent one
            if (w_rollback) begin
                r_err <= 1'b0;
            end else if (w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    // One-cycle event pulses and the registered-read valid strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
            r_wr_success    <= 1'b0;
            r_frame_dropped <= 1'b0;
            r_valid         <= 1'b0;
        end else begin
            r_overflow      <= w_ovf;
            r_underflow     <= re & w_empty;
            r_wr_success    <= w_wr;
            r_frame_dropped <= w_drop_pulse;
            r_valid         <= w_rd;
        end
    end

    // Committed-frame counter; commit and eop read in the same cycle cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else begin
            case ({w_commit, w_rd_eop})
                2'b10: if (r_pkt_cnt != LP_PKT_MAX) r_pkt_cnt <= r_pkt_cnt + PKT_CNT_WIDTH'(1);
                2'b01: if (r_pkt_cnt != '0)         r_pkt_cnt <= r_pkt_cnt - PKT_CNT_WIDTH'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    assign valid    = SHOW_AHEAD_EN ? ~w_empty : r_valid;
    assign dout     = SHOW_AHEAD_EN ? (w_empty ? DOUT_INITVAL : w_ram_adat[DATA_WIDTH-1:0])
                                    : w_ram_qdat[DATA_WIDTH-1:0];
    assign dout_eop = SHOW_AHEAD_EN ? (~w_empty & w_ram_adat[DATA_WIDTH])
                                    : w_ram_qdat[DATA_WIDTH];

    assign empty_flag    = w_empty;
    assign full_flag     = w_full;
    assign aempty        = (w_rdusedw <= LP_AEMPTY);
    assign afull         = (w_wrusedw >= LP_AFULL);
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;
    assign wr_success    = r_wr_success;
    assign frame_dropped = r_frame_dropped;
    assign wrusedw       = w_wrusedw;
    assign rdusedw       = w_rdusedw;
    assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_udp_pkt_fifo.sv
// Self-checking bench: show-ahead and registered-read instances share stimulus and one queue-based model.
// Latency: outputs sampled on the falling edge after each driven rising edge.
// Backpressure: n/a.
module tb_udp_pkt_fifo;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] di = '0;
    logic          we = 1'b0, wr_eop = 1'b0, wr_drop = 1'b0, re = 1'b0;

    logic [DW-1:0] sa_dout, rg_dout;
    logic          sa_dout_eop, sa_valid, sa_empty, sa_aempty, sa_full, sa_afull;
    logic          sa_ovf, sa_und, sa_ws, sa_fd;
    logic          rg_dout_eop, rg_valid, rg_empty, rg_aempty, rg_full, rg_afull;
    logic          rg_ovf, rg_und, rg_ws, rg_fd;
    logic [AW:0]   sa_wu, sa_ru, rg_wu, rg_ru;
    logic [7:0]    sa_pc, rg_pc;

    always #5 clk = ~clk;

    udp_pkt_fifo #(.SHOW_AHEAD_EN(1'b1)) dut_sa (
        .clk(clk), .rst(rst), .di(di), .we(we), .wr_eop(wr_eop), .wr_drop(wr_drop), .re(re),
        .dout(sa_dout), .dout_eop(sa_dout_eop), .valid(sa_valid), .empty_flag(sa_empty),
        .aempty(sa_aempty), .full_flag(sa_full), .afull(sa_afull), .overflow(sa_ovf),
        .underflow(sa_und), .wr_success(sa_ws), .frame_dropped(sa_fd), .wrusedw(sa_wu),
        .rdusedw(sa_ru), .pkt_cnt(sa_pc));

    udp_pkt_fifo #(.SHOW_AHEAD_EN(1'b0)) dut_rg (
        .clk(clk), .rst(rst), .di(di), .we(we), .wr_eop(wr_eop), .wr_drop(wr_drop), .re(re),
        .dout(rg_dout), .dout_eop(rg_dout_eop), .valid(rg_valid), .empty_flag(rg_empty),
        .aempty(rg_aempty), .full_flag(rg_full), .afull(rg_afull), .overflow(rg_ovf),
        .underflow(rg_und), .wr_success(rg_ws), .frame_dropped(rg_fd), .wrusedw(rg_wu),
        .rdusedw(rg_ru), .pkt_cnt(rg_pc));

    // ---------------- reference model: committed and pending word queues ----------------
    typedef struct packed { logic eop; logic [DW-1:0] dat; } word_t;
    word_t         cq[$];
    word_t         pq[$];
    bit            m_err;
    int            m_pkt;
    bit            m_ovf, m_und, m_ws, m_fd;
    logic [DW-1:0] m_rg_dout;
    bit            m_rg_eop, m_rg_valid;

    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_update(bit r, bit w, bit e, bit d, bit rd_en, logic [DW-1:0] data);
        int  used;
        bit  full, empty, commit, eop_rd;
        word_t x;
        if (r) begin
            cq.delete(); pq.delete();
            m_err = 0; m_pkt = 0;
            m_ovf = 0; m_und = 0; m_ws = 0; m_fd = 0;
            m_rg_dout = '0; m_rg_eop = 0; m_rg_valid = 0;
            return;
        end
        used   = cq.size() + pq.size();
        full   = (used == DEPTH);
        empty  = (cq.size() == 0);
        m_ovf  = w & full & !d;
        m_ws   = w & !full & !d;
        m_und  = rd_en & empty;
        m_fd   = 0;
        commit = 0;
        eop_rd = 0;
        m_rg_valid = 0;
        if (rd_en && !empty) begin
            x = cq.pop_front();
            m_rg_dout = x.dat; m_rg_eop = x.eop; m_rg_valid = 1; eop_rd = x.eop;
        end
        if (d) begin
            m_fd = (pq.size() != 0);
            pq.delete(); m_err = 0;
        end else if (w) begin
            if (full) begin
                if (e) begin pq.delete(); m_err = 0; m_fd = 1; end
                else m_err = 1;
            end else if (e && m_err) begin
                pq.delete(); m_err = 0; m_fd = 1;
            end else begin
                pq.push_back({e, data});
                if (e) begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                    commit = 1;
                end
            end
        end
        if (commit && !eop_rd)      begin if (m_pkt < 255) m_pkt++; end
        else if (!commit && eop_rd) begin if (m_pkt > 0)   m_pkt--; end
    endtask

    task automatic check_dut(string t, bit sa_mode, logic [AW:0] wu, logic [AW:0] ru,
                             logic ef, logic ae, logic ff, logic af, logic ov, logic un,
                             logic ws, logic fd, logic [7:0] pc, logic v, logic [DW-1:0] d,
                             logic de);
        int used = cq.size() + pq.size();
        int rd   = cq.size();
        check({t, ".wrusedw"},  64'(wu), 64'(used));
        check({t, ".rdusedw"},  64'(ru), 64'(rd));
        check({t, ".empty"},    64'(ef), 64'(rd == 0));
        check({t, ".aempty"},   64'(ae), 64'(rd <= 2));
        check({t, ".full"},     64'(ff), 64'(used == DEPTH));
        check({t, ".afull"},    64'(af), 64'(used >= DEPTH - 3));
        check({t, ".overflow"}, 64'(ov), 64'(m_ovf));
        check({t, ".underflow"},64'(un), 64'(m_und));
        check({t, ".wr_success"},64'(ws), 64'(m_ws));
        check({t, ".dropped"},  64'(fd), 64'(m_fd));
        check({t, ".pkt_cnt"},  64'(pc), 64'(m_pkt));
        if (sa_mode) begin
            check({t, ".valid"},    64'(v),  64'(rd != 0));
            check({t, ".dout"},     64'(d),  64'((rd != 0) ? cq[0].dat : '0));
            check({t, ".dout_eop"}, 64'(de), 64'((rd != 0) ? cq[0].eop : 1'b0));
        end else begin
            check({t, ".valid"},    64'(v),  64'(m_rg_valid));
            check({t, ".dout"},     64'(d),  64'(m_rg_dout));
            check({t, ".dout_eop"}, 64'(de), 64'(m_rg_eop));
        end
    endtask

    task automatic check_all();
        check_dut("sa", 1'b1, sa_wu, sa_ru, sa_empty, sa_aempty, sa_full, sa_afull, sa_ovf,
                  sa_und, sa_ws, sa_fd, sa_pc, sa_valid, sa_dout, sa_dout_eop);
        check_dut("rg", 1'b0, rg_wu, rg_ru, rg_empty, rg_aempty, rg_full, rg_afull, rg_ovf,
                  rg_und, rg_ws, rg_fd, rg_pc, rg_valid, rg_dout, rg_dout_eop);
    endtask

    // Drive one cycle of inputs, advance the model, check on the falling edge
    task automatic step(bit r, bit w, bit e, bit d, bit rd_en, logic [DW-1:0] data);
        rst = r; we = w; wr_eop = e; wr_drop = d; re = rd_en; di = data;
        model_update(r, w, e, d, rd_en, data);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit we, eop, drop, re;
        logic [DW-1:0] di;
        int wu; bit ef; int pc;
        logic [DW-1:0] sad; bit sae;
        logic [DW-1:0] rgd; bit rge, rgv, fd;
    } vec_t;

    function automatic vec_t mk(bit w, bit e, bit d, bit r, logic [DW-1:0] x, int wu, bit ef,
                                int pc, logic [DW-1:0] sad, bit sae, logic [DW-1:0] rgd,
                                bit rge, bit rgv, bit fd);
        vec_t v;
        v.we = w; v.eop = e; v.drop = d; v.re = r; v.di = x;
        v.wu = wu; v.ef = ef; v.pc = pc; v.sad = sad; v.sae = sae;
        v.rgd = rgd; v.rge = rge; v.rgv = rgv; v.fd = fd;
        return v;
    endfunction

    localparam logic [DW-1:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001;
    localparam logic [DW-1:0] A2 = 32'hA000_0002, A3 = 32'hA000_0003;
    localparam logic [DW-1:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001, B2 = 32'hB000_0002;

    vec_t tbl[13];
    int   ovf_cnt, fd_cnt, fd_idx;

    initial begin
        // 4-word frame in, 4 words out, then a 3-word frame aborted, then an empty abort
        tbl[0]  = mk(1,0,0,0,A0, 1,1,0, '0,0, '0,0,0, 0);
        tbl[1]  = mk(1,0,0,0,A1, 2,1,0, '0,0, '0,0,0, 0);
        tbl[2]  = mk(1,0,0,0,A2, 3,1,0, '0,0, '0,0,0, 0);
        tbl[3]  = mk(1,1,0,0,A3, 4,0,1, A0,0, '0,0,0, 0);
        tbl[4]  = mk(0,0,0,1,'0, 3,0,1, A1,0, A0,0,1, 0);
        tbl[5]  = mk(0,0,0,1,'0, 2,0,1, A2,0, A1,0,1, 0);
        tbl[6]  = mk(0,0,0,1,'0, 1,0,1, A3,1, A2,0,1, 0);
        tbl[7]  = mk(0,0,0,1,'0, 0,1,0, '0,0, A3,1,1, 0);
        tbl[8]  = mk(1,0,0,0,B0, 1,1,0, '0,0, A3,1,0, 0);
        tbl[9]  = mk(1,0,0,0,B1, 2,1,0, '0,0, A3,1,0, 0);
        tbl[10] = mk(1,0,0,0,B2, 3,1,0, '0,0, A3,1,0, 0);
        tbl[11] = mk(0,0,1,0,'0, 0,1,0, '0,0, A3,1,0, 1);
        tbl[12] = mk(0,0,1,0,'0, 0,1,0, '0,0, A3,1,0, 0);

        step(1, 0, 0, 0, 0, '0);
        check("reset.empty", 64'(sa_empty & rg_empty & sa_aempty), 64'(1));

        for (int i = 0; i < 13; i++) begin
            step(0, tbl[i].we, tbl[i].eop, tbl[i].drop, tbl[i].re, tbl[i].di);
            check($sformatf("tbl%0d.wrusedw", i),  64'(sa_wu),       64'(tbl[i].wu));
            check($sformatf("tbl%0d.empty", i),    64'(sa_empty),    64'(tbl[i].ef));
            check($sformatf("tbl%0d.pkt_cnt", i),  64'(rg_pc),       64'(tbl[i].pc));
            check($sformatf("tbl%0d.sa_dout", i),  64'(sa_dout),     64'(tbl[i].sad));
            check($sformatf("tbl%0d.sa_eop", i),   64'(sa_dout_eop), 64'(tbl[i].sae));
            check($sformatf("tbl%0d.rg_dout", i),  64'(rg_dout),     64'(tbl[i].rgd));
            check($sformatf("tbl%0d.rg_eop", i),   64'(rg_dout_eop), 64'(tbl[i].rge));
            check($sformatf("tbl%0d.rg_valid", i), 64'(rg_valid),    64'(tbl[i].rgv));
            check($sformatf("tbl%0d.dropped", i),  64'(sa_fd),       64'(tbl[i].fd));
        end

        // Underflow on an empty FIFO
        step(0, 0, 0, 0, 1, '0);
        check("underflow.pulse", 64'(sa_und & rg_und), 64'(1));

        // 130-word frame into a 128-deep FIFO: two overflows, rollback at eop
        step(1, 0, 0, 0, 0, '0);
        ovf_cnt = 0; fd_cnt = 0; fd_idx = -1;
        for (int i = 0; i < 130; i++) begin
            step(0, 1, i == 129, 0, 0, 32'h1000 + i);
            if (sa_ovf) ovf_cnt++;
            if (sa_fd) begin fd_cnt++; fd_idx = i; end
            if (i == 127) check("ovf130.full_at_128", 64'(sa_full), 64'(1));
        end
        check("ovf130.overflow_count", 64'(ovf_cnt), 64'(2));
        check("ovf130.drop_count", 64'(fd_cnt), 64'(1));
        check("ovf130.drop_at_eop", 64'(fd_idx), 64'(129));
        check("ovf130.wrusedw", 64'(sa_wu), 64'(0));

        // Committed full frame, then one extra word overflows; data still reads back
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, i == DEPTH - 1, 0, 0, 32'h2000 + i);
        check("full.flag", 64'(sa_full & rg_full), 64'(1));
        step(0, 1, 0, 0, 0, 32'hDEAD);
        check("full.overflow", 64'(sa_ovf), 64'(1));
        step(0, 0, 0, 1, 0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 0, 1, '0);
            check($sformatf("full.readback%0d", i), 64'(rg_dout), 64'(32'h2000 + i));
        end
        check("full.drained_pkt", 64'(sa_pc), 64'(0));

        // Commit of B coinciding with the eop read of A keeps pkt_cnt at 1
        step(1, 0, 0, 0, 0, '0);
        step(0, 1, 1, 0, 0, 32'hA1);
        step(0, 1, 0, 0, 0, 32'hB0);
        step(0, 1, 1, 0, 1, 32'hB1);
        check("simul.pkt_cnt_sa", 64'(sa_pc), 64'(1));
        check("simul.pkt_cnt_rg", 64'(rg_pc), 64'(1));
        check("simul.rg_eop", 64'(rg_dout_eop), 64'(1));
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);

        // Randomised traffic, mostly single-word frames, across several pointer wraps
        for (int i = 0; i < 1200; i++) begin
            step(0, $urandom_range(0, 99) < 60, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 99) < 55, DW'($urandom));
        end

        // Reset in the middle of a frame with committed data present
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 32'h3000 + i);
        step(0, 1, 0, 0, 0, 32'h3100);
        step(0, 1, 0, 0, 0, 32'h3101);
        step(1, 1, 0, 0, 1, 32'h3102);
        check("midrst.empty", 64'(sa_empty & rg_empty), 64'(1));
        check("midrst.wrusedw", 64'(sa_wu), 64'(0));
        check("midrst.pkt_cnt", 64'(rg_pc), 64'(0));
        check("midrst.rg_dout", 64'(rg_dout), 64'(0));
        step(0, 1, 1, 0, 0, 32'h4000);
        step(0, 0, 0, 0, 1, '0);
        check("postrst.readback", 64'(rg_dout), 64'(32'h4000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
